// File: rtl/rr_mux_pkg.sv
// Shared constants and sizing helper for rr_mux and its arbiter.
`include "mux_defs.vh"

package rr_mux_pkg;
  localparam int MUX_MODE_FIXED = `MUX_MODE_FIXED;
  localparam int MUX_MODE_RR    = `MUX_MODE_RR;

  // Index width for n channels, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_defs.vh
// Mode encodings shared by every mux variant in this codebase.
`ifndef MUX_DEFS_VH
`define MUX_DEFS_VH
`define MUX_MODE_FIXED 0
`define MUX_MODE_RR    1
`endif

// File: rtl/rr_arbiter.sv
// One-hot grant over req, fixed or round-robin from ptr; combinational grant, ptr updates on grant.
// No backpressure of its own: en gates all grants.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                en,
  input  logic                mode,
  output logic [CHANNELS-1:0] grant,
  output logic [SELW-1:0]     grant_idx
);

  logic [SELW-1:0] ptr;
  logic            found;
  int              j;

  // Walk upward from the search start, wrapping once around the channel set.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    if (en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        j = (mode ? int'(ptr) : 0) + i;
        if (j >= CHANNELS) j = j - CHANNELS;
        if (!found && req[j]) begin
          grant[j]  = 1'b1;
          grant_idx = SELW'(j);
          found     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (mode && found) begin
      ptr <= (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SELW'(1);
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-to-1 valid/ready mux into a one-entry output register; 1-cycle latency.
// Loads only when the register is empty or draining; all in_ready low otherwise.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = 1,
  localparam int SELW    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic                load_en;
  logic [CHANNELS-1:0] grant;
  logic [SELW-1:0]     grant_idx;
  logic [WIDTH-1:0]    sel_data;

  assign load_en  = !out_valid || out_ready;
  assign in_ready = grant;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SELW     (SELW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .en        (load_en && !rst),
    .mode      (MODE == MUX_MODE_RR),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is one-hot, so an AND-OR selects without any priority chain.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_en) begin
      out_valid <= |grant;
      if (|grant) begin
        out_data <= sel_data;
        out_sel  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Bench for rr_mux: three parameterisations driven in lockstep against a queue scoreboard.
module tb_rr_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] in_data_a, in_data_b;
  logic [3:0]  in_valid_a, in_ready_a, in_valid_b, in_ready_b;
  logic [7:0]  out_data_a, out_data_b;
  logic [1:0]  out_sel_a, out_sel_b;
  logic        out_valid_a, out_ready_a, out_valid_b, out_ready_b;
  logic [1:0]  in_data_c, in_valid_c, in_ready_c;
  logic        out_data_c, out_sel_c, out_valid_c, out_ready_c;

  rr_mux #(.WIDTH(8), .CHANNELS(4), .MODE(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_sel(out_sel_a), .out_valid(out_valid_a), .out_ready(out_ready_a));

  rr_mux #(.WIDTH(8), .CHANNELS(4), .MODE(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_sel(out_sel_b), .out_valid(out_valid_b), .out_ready(out_ready_b));

  rr_mux #(.WIDTH(1), .CHANNELS(2), .MODE(1)) dut_c (
    .clk(clk), .rst(rst), .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .out_data(out_data_c), .out_sel(out_sel_c), .out_valid(out_valid_c), .out_ready(out_ready_c));

  typedef struct {
    int k;
    int sel;
    int dat;
  } beat_t;

  beat_t sb[$];
  int    ptr_m[3];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int head(input int k);
    foreach (sb[i]) if (sb[i].k == k) return i;
    return -1;
  endfunction

  // Reference arbitration: held beat occupancy comes from the scoreboard itself.
  task automatic predict(input int k, input int n, input int w, input int mode,
                         input logic [15:0] vld, input logic [15:0] rdy,
                         input logic [63:0] dat, input logic ordy);
    int h, g, j;
    logic [15:0] exp_rdy;
    beat_t b;
    h = head(k);
    g = -1;
    if (h < 0 || ordy) begin
      for (int i = 0; i < n; i++) begin
        j = (mode == 1) ? (ptr_m[k] + i) % n : i;
        if (g < 0 && vld[j]) g = j;
      end
    end
    exp_rdy = (g >= 0) ? (16'd1 << g) : 16'd0;
    check_eq($sformatf("in_ready[%0d]", k), 64'(rdy), 64'(exp_rdy));
    if (h >= 0 && ordy) sb.delete(h);
    if (g >= 0) begin
      b.k   = k;
      b.sel = g;
      b.dat = int'((dat >> (g * w)) & ((64'd1 << w) - 64'd1));
      sb.push_back(b);
      if (mode == 1) ptr_m[k] = (g + 1) % n;
    end
  endtask

  task automatic observe(input int k, input logic ov, input int sel, input int dat);
    int h;
    h = head(k);
    check_eq($sformatf("out_valid[%0d]", k), 64'(ov), 64'(h >= 0));
    if (h >= 0 && ov) begin
      check_eq($sformatf("out_sel[%0d]", k), 64'(sel), 64'(sb[h].sel));
      check_eq($sformatf("out_data[%0d]", k), 64'(dat), 64'(sb[h].dat));
    end
  endtask

  // Called just after a rising edge; predicts before the next edge, observes after it.
  task automatic tick();
    #2;
    predict(0, 4, 8, 1, 16'(in_valid_a), 16'(in_ready_a), 64'(in_data_a), out_ready_a);
    predict(1, 4, 8, 0, 16'(in_valid_b), 16'(in_ready_b), 64'(in_data_b), out_ready_b);
    predict(2, 2, 1, 1, 16'(in_valid_c), 16'(in_ready_c), 64'(in_data_c), out_ready_c);
    @(posedge clk);
    #1;
    observe(0, out_valid_a, int'(out_sel_a), int'(out_data_a));
    observe(1, out_valid_b, int'(out_sel_b), int'(out_data_b));
    observe(2, out_valid_c, int'(out_sel_c), int'(out_data_c));
  endtask

  task automatic randomize_data();
    in_data_a = $urandom;
    in_data_b = $urandom;
    in_data_c = 2'($urandom);
  endtask

  initial begin
    ptr_m = '{0, 0, 0};
    in_valid_a = 4'hF; in_valid_b = 4'hA; in_valid_c = 2'b11;
    out_ready_a = 1'b1; out_ready_b = 1'b1; out_ready_c = 1'b1;
    randomize_data();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid_a), 64'd0);
    check_eq("rst_out_data", 64'(out_data_a), 64'd0);
    check_eq("rst_out_sel", 64'(out_sel_a), 64'd0);
    check_eq("rst_in_ready_a", 64'(in_ready_a), 64'd0);
    check_eq("rst_in_ready_c", 64'(in_ready_c), 64'd0);
    rst = 1'b0;

    // Saturated inputs: rotation on A and C, fixed priority on B.
    for (int c = 0; c < 5; c++) begin
      randomize_data();
      tick();
      check_eq("rr_seq", 64'(out_sel_a), 64'(c % 4));
      check_eq("fixed_sel", 64'(out_sel_b), 64'd1);
      check_eq("w1_seq", 64'(out_sel_c), 64'(c % 2));
    end

    // Backpressure on A with a known beat held.
    in_valid_a = 4'b0010;
    in_data_a  = 32'h0000_A500;
    tick();
    check_eq("bp_load", 64'(out_data_a), 64'hA5);
    out_ready_a = 1'b0;
    in_valid_a  = 4'hF;
    in_data_a   = $urandom;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("bp_hold_data", 64'(out_data_a), 64'hA5);
      check_eq("bp_hold_rdy", 64'(in_ready_a), 64'd0);
    end
    out_ready_a = 1'b1;
    tick();
    check_eq("bp_release_sel", 64'(out_sel_a), 64'd2);

    // ptr is 3 here: a lone channel-0 request must wrap, leaving ptr at 1.
    in_valid_a = 4'b0001;
    tick();
    check_eq("wrap_sel", 64'(out_sel_a), 64'd0);
    in_valid_a = 4'b0011;
    tick();
    check_eq("wrap_ptr", 64'(out_sel_a), 64'd1);
    in_valid_a = 4'b0000;
    tick();
    check_eq("drain_empty", 64'(out_valid_a), 64'd0);

    for (int c = 0; c < 80; c++) begin
      randomize_data();
      in_valid_a = 4'($urandom); in_valid_b = 4'($urandom); in_valid_c = 2'($urandom);
      out_ready_a = ($urandom_range(0, 3) != 0);
      out_ready_b = ($urandom_range(0, 3) != 0);
      out_ready_c = ($urandom_range(0, 1) != 0);
      tick();
    end

    // Reset while a beat is held must clear outputs without a clock edge.
    in_valid_a = 4'hF; out_ready_a = 1'b0;
    tick();
    check_eq("pre_rst_valid", 64'(out_valid_a), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 64'(out_valid_a), 64'd0);
    check_eq("mid_rst_sel", 64'(out_sel_a), 64'd0);
    check_eq("mid_rst_rdy", 64'(in_ready_a), 64'd0);
    check_eq("mid_rst_valid_b", 64'(out_valid_b), 64'd0);
    check_eq("mid_rst_valid_c", 64'(out_valid_c), 64'd0);
    sb.delete();
    ptr_m = '{0, 0, 0};
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int c = 0; c < 20; c++) begin
      randomize_data();
      in_valid_a = 4'($urandom); in_valid_b = 4'($urandom); in_valid_c = 2'($urandom);
      out_ready_a = ($urandom_range(0, 2) != 0);
      out_ready_b = ($urandom_range(0, 2) != 0);
      out_ready_c = ($urandom_range(0, 2) != 0);
      tick();
    end

    in_valid_a = '0; in_valid_b = '0; in_valid_c = '0;
    out_ready_a = 1'b1; out_ready_b = 1'b1; out_ready_c = 1'b1;
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
